// File: rtl/adc_tdm_pkg.sv
// Shared types and helpers for the adc_tdm_rx serial ADC receiver.
package adc_tdm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RECV = 2'd2
    } state_t;

    // Counter width for values 0..value-1, never narrower than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/adc_tdm_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module adc_tdm_fifo
    import adc_tdm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) wptr <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + 1'b1;
            if (rd_ok) rptr <= (rptr == AW'(DEPTH-1)) ? '0 : rptr + 1'b1;
            count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= wr_data;
    end

endmodule

// File: rtl/adc_tdm_rx.sv
// Frame-sync TDM serial ADC receiver with AXI4-Stream output.
// Optional clip detector output enabled by defining ADC_TDM_CLIP_DET_EN.
module adc_tdm_rx
    import adc_tdm_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DW         = 24,
    parameter int SLOT       = 32,
    parameter int LAST       = 10240,
    parameter int FIFO_DEPTH = 8,
    parameter int SYNC_STG   = 2,
    parameter int START_DLY  = 300,
    localparam int TW        = clog2(NCH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          sck,
    input  logic          fsync,
    input  logic          dout,
    output logic          start,
    output logic          reset_n,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [DW-1:0] m_axis_tdata,
    output logic [TW-1:0] m_axis_tuser,
    output logic          m_axis_tlast,
    output logic          ovf,
    output logic          frame_err
`ifdef ADC_TDM_CLIP_DET_EN
    ,
    output logic [NCH-1:0] clip
`endif
);

    localparam int BW = clog2(SLOT);
    localparam int CW = clog2(START_DLY + 1);
    localparam int LW = clog2(LAST);

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } fifo_word_t;

    logic [SYNC_STG-1:0] sck_sync, fsync_sync, dout_sync;
    logic                sck_d, fsync_d;
    logic                sck_rise, fsync_rise, dout_s;

    state_t          state;
    logic [BW-1:0]   bit_cnt, cur_bit;
    logic [TW-1:0]   slot_cnt, cur_slot;
    logic [SLOT-1:0] shreg, shift_nxt;
    logic [CW-1:0]   start_cnt;
    logic [LW-1:0]   beat_cnt;
    logic            arm_edge, take_bit, push, pop, fifo_full, fifo_empty;
    fifo_word_t      push_word, rd_word;

    assign reset_n = rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync   <= '0;
            fsync_sync <= '0;
            dout_sync  <= '0;
            sck_d      <= 1'b0;
            fsync_d    <= 1'b0;
        end else begin
            sck_sync   <= (sck_sync << 1) | SYNC_STG'(sck);
            fsync_sync <= (fsync_sync << 1) | SYNC_STG'(fsync);
            dout_sync  <= (dout_sync << 1) | SYNC_STG'(dout);
            sck_d      <= sck_sync[SYNC_STG-1];
            fsync_d    <= fsync_sync[SYNC_STG-1];
        end
    end

    assign sck_rise   = sck_sync[SYNC_STG-1] && !sck_d;
    assign fsync_rise = fsync_sync[SYNC_STG-1] && !fsync_d;
    assign dout_s     = dout_sync[SYNC_STG-1];

    // An fsync edge that arms or restarts a frame also makes a coincident
    // sck edge bit 0 of slot 0.
    always_comb begin
        arm_edge       = fsync_rise && ((state == ARM && en) || state == RECV);
        take_bit       = sck_rise && (state == RECV || (state == ARM && en && fsync_rise));
        cur_bit        = arm_edge ? '0 : bit_cnt;
        cur_slot       = arm_edge ? '0 : slot_cnt;
        shift_nxt      = (shreg << 1) | SLOT'(dout_s);
        push           = take_bit && (cur_bit == BW'(SLOT-1));
        push_word.tag  = cur_slot;
        push_word.data = shift_nxt[SLOT-1 -: DW];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            slot_cnt  <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            frame_err <= fsync_rise && (state == RECV);
            ovf       <= push && fifo_full && !pop;
            if (take_bit) shreg <= shift_nxt;
            case (state)
                IDLE: if (start) state <= ARM;
                ARM, RECV: begin
                    if (arm_edge) begin
                        state    <= RECV;
                        bit_cnt  <= '0;
                        slot_cnt <= '0;
                    end
                    if (take_bit) begin
                        if (push) begin
                            bit_cnt <= '0;
                            if (cur_slot == TW'(NCH-1)) begin
                                slot_cnt <= '0;
                                state    <= ARM;
                            end else begin
                                slot_cnt <= cur_slot + 1'b1;
                            end
                        end else begin
                            bit_cnt <= cur_bit + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_cnt <= '0;
            beat_cnt  <= '0;
        end else begin
            if (en && start_cnt < CW'(START_DLY)) start_cnt <= start_cnt + 1'b1;
            if (pop) beat_cnt <= (beat_cnt == LW'(LAST-1)) ? '0 : beat_cnt + 1'b1;
        end
    end

    assign start = (start_cnt == CW'(START_DLY));

    adc_tdm_fifo #(
        .WIDTH ($bits(fifo_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (push_word),
        .rd_en   (pop),
        .rd_data (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tdata  = rd_word.data;
    assign m_axis_tuser  = rd_word.tag;
    assign m_axis_tlast  = m_axis_tvalid && (beat_cnt == LW'(LAST-1));

`ifdef ADC_TDM_CLIP_DET_EN
    // Top two bits differing means the sample sits in the outer quarter of range.
    always_ff @(posedge clk) begin
        if (!rst_n) clip <= '0;
        else if (push) clip[cur_slot] <= push_word.data[DW-1] ^ push_word.data[DW-2];
    end
`endif

endmodule

// File: doc/adc_tdm_rx.md
Name: adc_tdm_rx

Overview:
Multi-channel frame-sync serial receiver for ADS127L01-class ADCs, covering daisy-chained or TDM devices. It captures NCH slots of SLOT bits per frame from an externally clocked sck/fsync/dout interface. Each slot's DW most-significant bits go into a small FIFO and are emitted as an AXI4-Stream with a channel tag. It sits between the ADC pins and the DMA/packetiser and also drives the ADC's static configuration and start pins.

Parameters:
NCH, 4, channels (slots) per frame, 1..16
DW, 24, sample width taken from the MSBs of each slot
SLOT, 32, sck cycles per slot, SLOT >= DW
LAST, 10240, accepted beats per tlast packet
FIFO_DEPTH, 8, output FIFO words, power of two, >= NCH
SYNC_STG, 2, synchroniser flops on sck/fsync/dout, >= 1
START_DLY, 300, clk cycles of en before start asserts

Ports:
clk  in  1  system clock; must run faster than 4x sck
rst_n  in  1  synchronous reset, active-low
en  in  1  capture enable
sck  in  1  ADC bit clock
fsync  in  1  ADC frame sync; rising edge marks bit 0 of slot 0
dout  in  1  ADC serial data, MSB first
start  out  1  ADC START pin
reset_n  out  1  ADC RESET pin, equal to rst_n
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tdata  out  DW  sample
m_axis_tuser  out  $clog2(NCH)>1?$clog2(NCH):1  channel index
m_axis_tlast  out  1  last beat of a LAST-beat packet
ovf  out  1  one-cycle pulse when a sample is dropped because the FIFO is full
frame_err  out  1  one-cycle pulse on a short frame

Behaviour:
- Reset values: all outputs 0 except reset_n; all state registers cleared; FIFO emptied; FSM in IDLE.
- Synchronisers: sck, fsync and dout each pass through SYNC_STG flops. Edge detect on the last stage compared with one extra delay flop.
- Start counter: increments while en and below START_DLY. start = (count == START_DLY) and stays high until reset. Deasserting en freezes the counter.
- FSM states:
  - IDLE: leave when start is high.
  - ARM: wait for an fsync rising edge while en is high.
  - RECV: capture bits.
- ARM -> RECV on an fsync rising edge. This edge clears bit_cnt and slot_cnt.
- RECV, on each sck rising edge: shift dout into the shift register, bit_cnt++.
- RECV, at the rising edge where bit_cnt == SLOT-1:
  - push the shift register's top DW bits (current bit included) with tag slot_cnt;
  - clear bit_cnt and increment slot_cnt;
  - after slot NCH-1, return to ARM.
- RECV, fsync rising edge before the frame completes: pulse frame_err, discard the partial slot, restart at slot 0 and stay in RECV. Words already pushed for that frame are kept.
- Simultaneous fsync and sck rising edges in ARM: the fsync edge arms the frame and the sck edge is taken as bit 0.
- en low in RECV: finish the current frame, then go to ARM and stay there until en returns.
- FIFO full on push: drop the word and pulse ovf. The FIFO contents are not altered.
- Push and pop in the same cycle while the FIFO is full: the push is accepted.
- Stream handshake:
  - tvalid = FIFO not empty, registered output with first-word latency of 1 clk after push;
  - tdata, tuser and tlast hold while tvalid && !tready.
- Beat counter: counts tvalid && tready. tlast = (beat_cnt == LAST-1); the counter wraps to 0 on that beat.
- Reset mid-frame: partial data is discarded and the FSM returns to IDLE; start drops, so the ADC restarts.

Optional Feature:
- Macro ADC_TDM_CLIP_DET_EN.
- Enabled:
  - adds output clip[NCH-1:0];
  - bit ch is set when a pushed sample for ch has tdata[DW-1] != tdata[DW-2], i.e. near full scale;
  - bit ch clears when a later sample for ch has equal top bits;
  - reset value is 0.
- Disabled: the port and its logic are absent.

Decomposition:
- Package adc_tdm_pkg:
  - state_t enum {IDLE, ARM, RECV};
  - function clog2 helper for counter widths;
  - fifo word struct {tag, data}.
- Sub-module adc_tdm_fifo: synchronous FWFT FIFO, parametrised by width and depth, with full/empty flags and the full-and-pop acceptance rule.
- Synchroniser/edge detection stays inline.

Test Plan:
- Reset, en=1, count clk cycles: start rises exactly 300 clk after en; tvalid stays 0 with no fsync.
- NCH=4, slots carrying 0xA5A5A5xx, 0x123456xx, 0x800000xx, 0x7FFFFFxx, tready=1: four beats with tdata A5A5A5, 123456, 800000, 7FFFFF and tuser 0,1,2,3.
- tready=0 for three full frames with FIFO_DEPTH=8: 8 words retained; ovf pulses 4 times; on release the first word out is frame 1, ch0.
- fsync re-rises after slot 1 bit 10: frame_err pulses once; next 4 beats are a clean frame with tuser 0..3.
- LAST=8, tready toggling 50%: tlast on beats 8 and 16 only; no beat is lost or duplicated.
- With ADC_TDM_CLIP_DET_EN, ch2 fed 0x400000 then 0x100000: clip[2] goes 1, then 0.
